sample_stream_player: RTL
=========================

Name: sample_stream_player

Overview:
- Memory-backed stream source that produces the sample stream a downstream FIR/convolution block consumes on its data_in/data_valid inputs.
- Host software loads samples into an internal BRAM through a write port.
- A playback FSM reads the samples back in order and presents them on a valid/ready output.
- Output pacing is programmable (inter-sample gap), with optional looping.

Parameters:
- DATA_WIDTH, 8, sample width in bits.
- DEPTH, 16, number of sample words in the BRAM (power of two).
- ADDR_WIDTH, $clog2(DEPTH), address width (derived; not overridden).
- GAP_WIDTH, 8, width of the inter-sample gap field.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wr_en  in  1  sample memory write strobe.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- start  in  1  begin playback (pulse).
- stop  in  1  abort playback (pulse).
- length  in  ADDR_WIDTH+1  number of samples to play, 0..DEPTH.
- loop  in  1  1 = wrap to address 0 after the last sample and continue.
- gap  in  GAP_WIDTH  idle cycles inserted after each accepted sample.
- out_ready  in  1  downstream accept (tie high for a consumer without backpressure).
- data_out  out  DATA_WIDTH  current sample.
- data_valid  out  1  data_out holds a valid sample.
- busy  out  1  playback in progress.
- done  out  1  one-cycle pulse when a non-looping playback completes.

Behaviour:
- Reset values: data_out=0, data_valid=0, busy=0, done=0, state=IDLE, address and gap counters 0. Memory contents are not reset.
- Reset asserted mid-playback aborts immediately. No done pulse.
- Memory:
  - Simple dual-port BRAM, synchronous read, one-cycle latency, read-first.
  - A write and a read to the same address in the same cycle returns the old data.
  - Writes are accepted in every state, including during playback.
- FSM states: IDLE, SEND, GAP.
- Parameter capture: length, loop and gap are captured on start. length > DEPTH is clamped to DEPTH.
- IDLE:
  - start with length != 0: issue a read of address 0, busy=1 the next cycle, go to SEND. data_valid=1 with mem[0] on cycle start+1.
  - start with length == 0: no read; done=1 on the next cycle; stay in IDLE.
  - stop in IDLE is ignored.
- SEND (data_valid=1):
  - data_out and data_valid are held stable while out_ready=0. No read is issued.
  - Handshake is data_valid & out_ready.
  - On handshake, if the accepted sample is not the last and gap==0: read the next address in the same cycle. The next sample is valid the following cycle (back-to-back, one sample per cycle).
  - On handshake, if the accepted sample is not the last and gap>0: data_valid=0 the next cycle, load the gap counter, go to GAP.
- GAP:
  - Counts gap cycles. The read is issued on the final gap cycle.
  - The sample accepted at cycle t is followed by the next valid sample at exactly t+gap+1.
- End of sequence (handshake on index length-1):
  - loop=1: next address wraps to 0 and playback continues, with the gap rules unchanged.
  - loop=0: data_valid=0 and busy=0 the next cycle, done=1 for one cycle, go to IDLE.
  - With loop=0 and gap>0, no gap is inserted after the last sample.
- stop while busy (any state):
  - Next cycle: data_valid=0, busy=0, state=IDLE, no done pulse.
  - A handshake coinciding with stop counts as consumed.
  - stop and start in the same cycle: stop wins.
- start while busy is ignored (captured parameters are unchanged).
- Counters:
  - The address counter is ADDR_WIDTH bits with natural wrap.
  - The sample index counter is ADDR_WIDTH+1 bits so that length=DEPTH is representable.
- busy is high from the cycle after an accepted start until the cycle after the final handshake or stop.

Decomposition:
- Package sample_stream_pkg holds:
  - the state enum (IDLE, SEND, GAP);
  - the default widths DATA_WIDTH=8, DEPTH=16, GAP_WIDTH=8.
- Sub-module sample_ram: parameterized simple dual-port, synchronous read-first BRAM with a read enable and a write port.
- The FSM, the counters and the output flags stay in sample_stream_player.

Test Plan:
- Load mem[0..7]=1..8, then start with length=8, gap=0, loop=0, out_ready=1.
  -> data_valid high on cycles 1..8 with data_out 1..8; done pulses on cycle 9; busy low on cycle 9.
- Same load, gap=2, out_ready=1.
  -> valid samples spaced exactly 3 cycles apart (1 valid, 2 idle), 8 samples total, then done.
- Backpressure: length=4; out_ready=0 for 5 cycles while the first sample is presented.
  -> data_out=1 held stable with data_valid=1; sample 2 appears the cycle after out_ready rises; exactly 4 handshakes.
- loop=1, length=3: accept 7 handshakes.
  -> sequence 1,2,3,1,2,3,1; no done pulse.
  -> stop then drops data_valid and busy next cycle, with no done.
- length=0 start -> done on the next cycle, data_valid never asserted.
- length=20 (clamped) -> exactly 16 samples, then done.
- Write mem[2]=0xAA during playback of length=8 before index 2 is read -> sample 3 reads 0xAA.
- Assert rst while in GAP -> all outputs 0 asynchronously.
- After rst, start -> playback restarts from mem[0].

Source files
------------

// File: rtl/sample_stream_pkg.sv
// Shared types and default widths for the sample stream player.
package sample_stream_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_DEPTH      = 16;
  localparam int unsigned DEF_GAP_WIDTH  = 8;

  // Playback FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/sample_stream_player_ram.sv
// Simple dual-port sample memory: synchronous write, synchronous read-first
// read with enable. The array is not reset; the read data register is.
// Ports:
//   clk, rst           clock, async active-high reset (read register only)
//   wr_en_i/addr/data  write port
//   rd_en_i/rd_addr_i  read request, data on rd_data_o one cycle later
module sample_ram
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Storage array; a same-address read in this cycle sees the old word.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
  end

  // Read data register; holds its value while no read is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sample_stream_player.sv
// Memory-backed sample source with programmable inter-sample gap and looping.
// Ports:
//   clk, rst                       clock, async active-high reset
//   wr_en, wr_addr, wr_data        host sample-memory write port
//   start, stop                    playback control pulses
//   length, loop, gap              playback parameters, captured on start
//   out_ready                      downstream accept
//   data_out, data_valid           sample stream output
//   busy, done                     playback status
module sample_stream_player
  import sample_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned GAP_WIDTH  = DEF_GAP_WIDTH,
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH),
  localparam int unsigned LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  input  logic                  stop,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic                  loop,
  input  logic [GAP_WIDTH-1:0]  gap,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  done
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  idx_q, idx_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic                  loop_q, loop_d;
  logic [GAP_WIDTH-1:0]  gap_q, gap_d;
  logic [GAP_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  hs;
  logic                  last;
  logic [ADDR_WIDTH-1:0] nxt_addr;
  logic [LEN_WIDTH-1:0]  nxt_idx;
  logic [LEN_WIDTH-1:0]  len_clamped;

  sample_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_addr),
    .rd_data_o (data_out)
  );

  assign hs          = valid_q & out_ready;
  assign last        = (idx_q + LEN_WIDTH'(1)) == len_q;
  // Past the last sample the sequence restarts at 0 (only reachable when looping).
  assign nxt_addr    = last ? '0 : addr_q + ADDR_WIDTH'(1);
  assign nxt_idx     = last ? '0 : idx_q + LEN_WIDTH'(1);
  assign len_clamped = (length > LEN_WIDTH'(DEPTH)) ? LEN_WIDTH'(DEPTH) : length;

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      idx_q     <= '0;
      len_q     <= '0;
      loop_q    <= 1'b0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      loop_q    <= loop_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state, counter and read-request logic.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    idx_d     = idx_q;
    len_d     = len_q;
    loop_d    = loop_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = addr_q;

    case (state_q)
      IDLE: begin
        // stop takes priority over a simultaneous start
        if (start && !stop) begin
          len_d  = len_clamped;
          loop_d = loop;
          gap_d  = gap;
          addr_d = '0;
          idx_d  = '0;
          if (length == '0) begin
            done_d = 1'b1;
          end else begin
            rd_en   = 1'b1;
            rd_addr = '0;
            valid_d = 1'b1;
            busy_d  = 1'b1;
            state_d = SEND;
          end
        end
      end

      SEND: begin
        if (stop) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (hs) begin
          if (last && !loop_q) begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            addr_d = nxt_addr;
            idx_d  = nxt_idx;
            if (gap_q == '0) begin
              rd_en   = 1'b1;
              rd_addr = nxt_addr;
            end else begin
              valid_d   = 1'b0;
              gap_cnt_d = gap_q;
              state_d   = GAP;
            end
          end
        end
      end

      GAP: begin
        if (stop) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (gap_cnt_q == GAP_WIDTH'(1)) begin
          // Final gap cycle: fetch so the sample is valid right after.
          rd_en     = 1'b1;
          rd_addr   = addr_q;
          valid_d   = 1'b1;
          gap_cnt_d = '0;
          state_d   = SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
        end
      end

      default: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign data_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
